id_ex_stage: RTL

Pipeline register between the Decode and Execute stages of the five-stage MIPS CPU, with an integrated load-use hazard detector. It captures decoded control bits, register-file read data, the sign-extended immediate and the Rs/Rt/Rd register numbers. It presents them to the Execute stage and to the forwarding unit as `ID_EX_*`. When a load in Execute feeds the instruction in Decode, it stalls the front end for one cycle and injects a bubble.

---
 rtl/mips_pkg.sv | 42 ++++
 rtl/load_use_detector.sv | 24 ++
 rtl/id_ex_stage.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: datapath widths, ALUOp encodings
// and the packed control bundle carried from Decode into Execute.
package mips_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned ALUOP_WIDTH    = 2;

    // ALU operation classes produced by the main decoder
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_MEM = 2'b00;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_BR  = 2'b01;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_R   = 2'b10;

    // Execute-stage controls
    typedef struct packed {
        logic                   alu_src;
        logic                   reg_dst;
        logic [ALUOP_WIDTH-1:0] alu_op;
    } ex_ctrl_t;

    // Memory-stage controls
    typedef struct packed {
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

    // Writeback-stage controls
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    typedef struct packed {
        wb_ctrl_t  wb;
        mem_ctrl_t mem;
        ex_ctrl_t  ex;
    } ctrl_t;

    // A bubble carries no side effects: no register write, no memory access
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detector.sv
// Load-use hazard detector.
// A load in Execute whose destination (Rt) is read by the Decode instruction
// forces a one-cycle stall; writes to $0 are never a hazard.
//   ID_EX_MemRead, ID_EX_RegisterRt  : load currently in Execute
//   IF_ID_RegisterRs/Rt              : source registers of the Decode instruction
//   Stall                            : combinational hazard flag
module load_use_detector #(
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      ID_EX_MemRead,
    input  logic [REG_ADDR_WIDTH-1:0] ID_EX_RegisterRt,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_RegisterRs,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_RegisterRt,
    output logic                      Stall
);

    always_comb begin
        Stall = ID_EX_MemRead
             && (ID_EX_RegisterRt != '0)
             && ((ID_EX_RegisterRt == IF_ID_RegisterRs)
              || (ID_EX_RegisterRt == IF_ID_RegisterRt));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with integrated load-use hazard handling.
// Captures decoded controls, register read data, the immediate, PC+4 and the
// Rs/Rt/Rd numbers; loads a bubble on Flush or on a load-use stall.
//   clk, reset              : clock, asynchronous active-high reset
//   Flush                   : squash the Decode instruction
//   IF_ID_Register*, ID_*   : Decode-stage instruction fields
//   ID_EX_*, ID_EX_Valid    : registered Execute-stage copies
//   PCWrite, IF_ID_Write    : front-end enables (0 = hold), combinational
module id_ex_stage #(
    parameter int unsigned DATA_WIDTH     = mips_pkg::DATA_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH = mips_pkg::REG_ADDR_WIDTH,
    parameter int unsigned ALUOP_WIDTH    = mips_pkg::ALUOP_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      Flush,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_RegisterRs,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_RegisterRt,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_RegisterRd,
    input  logic                      ID_RegWrite,
    input  logic                      ID_MemRead,
    input  logic                      ID_MemWrite,
    input  logic                      ID_MemtoReg,
    input  logic                      ID_ALUSrc,
    input  logic                      ID_RegDst,
    input  logic [ALUOP_WIDTH-1:0]    ID_ALUOp,
    input  logic [DATA_WIDTH-1:0]     ID_ReadData1,
    input  logic [DATA_WIDTH-1:0]     ID_ReadData2,
    input  logic [DATA_WIDTH-1:0]     ID_SignExtImm,
    input  logic [DATA_WIDTH-1:0]     ID_PCPlus4,
    output logic                      ID_EX_RegWrite,
    output logic                      ID_EX_MemRead,
    output logic                      ID_EX_MemWrite,
    output logic                      ID_EX_MemtoReg,
    output logic                      ID_EX_ALUSrc,
    output logic                      ID_EX_RegDst,
    output logic [ALUOP_WIDTH-1:0]    ID_EX_ALUOp,
    output logic [DATA_WIDTH-1:0]     ID_EX_ReadData1,
    output logic [DATA_WIDTH-1:0]     ID_EX_ReadData2,
    output logic [DATA_WIDTH-1:0]     ID_EX_SignExtImm,
    output logic [DATA_WIDTH-1:0]     ID_EX_PCPlus4,
    output logic [REG_ADDR_WIDTH-1:0] ID_EX_RegisterRs,
    output logic [REG_ADDR_WIDTH-1:0] ID_EX_RegisterRt,
    output logic [REG_ADDR_WIDTH-1:0] ID_EX_RegisterRd,
    output logic                      ID_EX_Valid,
    output logic                      PCWrite,
    output logic                      IF_ID_Write
);

    import mips_pkg::ctrl_t;
    import mips_pkg::CTRL_BUBBLE;

    localparam int unsigned PKG_ALUOP_W = mips_pkg::ALUOP_WIDTH;

    ctrl_t                     ctrl_d,  ctrl_q;
    logic [REG_ADDR_WIDTH-1:0] rs_d,    rs_q;
    logic [REG_ADDR_WIDTH-1:0] rt_d,    rt_q;
    logic [REG_ADDR_WIDTH-1:0] rd_d,    rd_q;
    logic [DATA_WIDTH-1:0]     rdata1_d, rdata1_q;
    logic [DATA_WIDTH-1:0]     rdata2_d, rdata2_q;
    logic [DATA_WIDTH-1:0]     imm_d,   imm_q;
    logic [DATA_WIDTH-1:0]     pc4_d,   pc4_q;
    logic                      valid_d, valid_q;
    logic                      stall;

    load_use_detector #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_load_use_detector (
        .ID_EX_MemRead    (ctrl_q.mem.mem_read),
        .ID_EX_RegisterRt (rt_q),
        .IF_ID_RegisterRs (IF_ID_RegisterRs),
        .IF_ID_RegisterRt (IF_ID_RegisterRt),
        .Stall            (stall)
    );

    // A flushed Decode instruction is discarded, so the front end may advance
    always_comb begin
        PCWrite     = !stall || Flush;
        IF_ID_Write = !stall || Flush;
    end

    // Next-state: bubble on Flush or Stall, otherwise capture Decode
    always_comb begin
        ctrl_d   = CTRL_BUBBLE;
        rs_d     = '0;
        rt_d     = '0;
        rd_d     = '0;
        rdata1_d = '0;
        rdata2_d = '0;
        imm_d    = '0;
        pc4_d    = '0;
        valid_d  = 1'b0;
        if (!(Flush || stall)) begin
            ctrl_d.wb.reg_write   = ID_RegWrite;
            ctrl_d.wb.mem_to_reg  = ID_MemtoReg;
            ctrl_d.mem.mem_read   = ID_MemRead;
            ctrl_d.mem.mem_write  = ID_MemWrite;
            ctrl_d.ex.alu_src     = ID_ALUSrc;
            ctrl_d.ex.reg_dst     = ID_RegDst;
            ctrl_d.ex.alu_op      = PKG_ALUOP_W'(ID_ALUOp);
            rs_d                  = IF_ID_RegisterRs;
            rt_d                  = IF_ID_RegisterRt;
            rd_d                  = IF_ID_RegisterRd;
            rdata1_d              = ID_ReadData1;
            rdata2_d              = ID_ReadData2;
            imm_d                 = ID_SignExtImm;
            pc4_d                 = ID_PCPlus4;
            valid_d               = 1'b1;
        end
    end

    // Pipeline register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q   <= CTRL_BUBBLE;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            pc4_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            pc4_q    <= pc4_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        ID_EX_RegWrite   = ctrl_q.wb.reg_write;
        ID_EX_MemtoReg   = ctrl_q.wb.mem_to_reg;
        ID_EX_MemRead    = ctrl_q.mem.mem_read;
        ID_EX_MemWrite   = ctrl_q.mem.mem_write;
        ID_EX_ALUSrc     = ctrl_q.ex.alu_src;
        ID_EX_RegDst     = ctrl_q.ex.reg_dst;
        ID_EX_ALUOp      = ALUOP_WIDTH'(ctrl_q.ex.alu_op);
        ID_EX_RegisterRs = rs_q;
        ID_EX_RegisterRt = rt_q;
        ID_EX_RegisterRd = rd_q;
        ID_EX_ReadData1  = rdata1_q;
        ID_EX_ReadData2  = rdata2_q;
        ID_EX_SignExtImm = imm_q;
        ID_EX_PCPlus4    = pc4_q;
        ID_EX_Valid      = valid_q;
    end

endmodule
